// File: rtl/fetch_unit.sv
// Instruction fetch unit: loadable instruction memory with a two-state fetcher
// that assembles one- or two-word instructions, with stall, redirect and reset.
module fetch_unit #(
    parameter int unsigned         DATA_W   = 16,
    parameter int unsigned         ADDR_W   = 32,
    parameter int unsigned         DEPTH    = 1024,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0,
    parameter int unsigned         LONG_BIT = DATA_W - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_W-1:0]     write_addr,
    input  logic [DATA_W-1:0]     write_data,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_W-1:0]     redirect_pc,
    output logic [2*DATA_W-1:0]   instr_out,
    output logic [ADDR_W-1:0]     pc_out,
    output logic                  valid_out
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_t;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_word;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic [ADDR_W-1:0]   start_pc_q, start_pc_d;
    logic [2*DATA_W-1:0] instr_d;
    logic [ADDR_W-1:0]   pc_out_d;
    logic                valid_d;

    // Upper address bits only wrap the memory index and are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{write_addr[ADDR_W-1:IDX_W], pc_q[ADDR_W-1:IDX_W]};

    // Load port; unaffected by reset so program contents survive it.
    always_ff @(posedge clk) begin
        if (write_enable) begin
            mem[write_addr[IDX_W-1:0]] <= write_data;
        end
    end

    // Combinational read sees the pre-write contents in a same-cycle write.
    assign rd_word = mem[pc_q[IDX_W-1:0]];

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_d     = hold_q;
        start_pc_d = start_pc_q;
        instr_d    = instr_out;
        pc_out_d   = pc_out;
        valid_d    = valid_out;

        if (redirect) begin
            pc_d    = redirect_pc;
            state_d = ST_FIRST;
            valid_d = 1'b0;
        end else if (!stall) begin
            pc_d = pc_q + ADDR_W'(1);
            unique case (state_q)
                ST_FIRST: begin
                    if (rd_word[LONG_BIT]) begin
                        hold_d     = rd_word;
                        start_pc_d = pc_q;
                        valid_d    = 1'b0;
                        state_d    = ST_SECOND;
                    end else begin
                        instr_d  = {rd_word, DATA_W'(0)};
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                    end
                end
                ST_SECOND: begin
                    instr_d  = {hold_q, rd_word};
                    pc_out_d = start_pc_q;
                    valid_d  = 1'b1;
                    state_d  = ST_FIRST;
                end
                default: state_d = ST_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FIRST;
            pc_q       <= RESET_PC;
            hold_q     <= '0;
            start_pc_q <= RESET_PC;
            instr_out  <= '0;
            pc_out     <= RESET_PC;
            valid_out  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_q     <= hold_d;
            start_pc_q <= start_pc_d;
            instr_out  <= instr_d;
            pc_out     <= pc_out_d;
            valid_out  <= valid_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16: instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 32: PC and address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1024: instruction memory depth in words; power of two, minimum 2.
REQ-004 SHALL have parameter RESET_PC, default 0: PC value after reset.
REQ-005 SHALL have parameter LONG_BIT, default DATA_W-1: bit of the first word that marks a two-word instruction.
REQ-006 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-008 SHALL have port write_enable, input, 1: memory load strobe.
REQ-009 SHALL have port write_addr, input, ADDR_W: load address (word index).
REQ-010 SHALL have port write_data, input, DATA_W: load data.
REQ-011 SHALL have port stall, input, 1: hold all fetch state.
REQ-012 SHALL have port redirect, input, 1: branch or flush request.
REQ-013 SHALL have port redirect_pc, input, ADDR_W: target PC for redirect.
REQ-014 SHALL have port instr_out, output, 2*DATA_W: fetched instruction, {first word, second word}.
REQ-015 SHALL have port pc_out, output, ADDR_W: PC of the first word of instr_out.
REQ-016 SHALL have port valid_out, output, 1: instr_out and pc_out hold a new instruction this cycle.

Function
REQ-017 Memory SHALL be DEPTH x DATA_W, indexed by address[log2(DEPTH)-1:0]; higher address bits ignored, so addresses wrap modulo DEPTH.
REQ-018 Load: write_enable=1 at an edge SHALL write write_data to mem[write_addr]. Writes are independent of stall, redirect and state.
REQ-019 Memory reads SHALL be combinational from the current PC. A same-cycle write to that address SHALL be visible only from the next cycle (read-old).
REQ-020 The FSM SHALL have two states. FIRST fetches the first or only word. SECOND fetches the second word of a long instruction.
REQ-021 FIRST, word w=mem[PC] with w[LONG_BIT]=0 (short): on the edge, instr_out={w, DATA_W'b0}, pc_out=PC, valid_out=1, PC<=PC+1, stay in FIRST.
REQ-022 FIRST, w[LONG_BIT]=1 (long): on the edge, latch w into an internal hold register, record PC as the start PC, set valid_out=0, PC<=PC+1, go to SECOND.
REQ-023 SECOND: on the edge, instr_out={hold, mem[PC]}, pc_out=start PC, valid_out=1, PC<=PC+1, go to FIRST. Short-instruction latency is 1 cycle and long is 2 cycles; a long instruction yields one valid_out pulse.
REQ-024 PC arithmetic SHALL be modulo 2^ADDR_W. Memory index wrap follows REQ-017, e.g. PC=DEPTH-1 -> PC=DEPTH reads mem[0].
REQ-025 stall=1 SHALL hold PC, state, hold register, instr_out, pc_out and valid_out unchanged. A stalled valid instruction therefore stays presented until stall falls.
REQ-026 redirect=1 SHALL set PC<=redirect_pc, state<=FIRST and valid_out<=0, and discard any half-fetched long instruction. instr_out and pc_out keep their old values.
REQ-027 Priority SHALL be rst > redirect > stall > normal fetch. redirect with stall=1 is taken, not held.
REQ-028 instr_out and pc_out SHALL change only on a cycle that also sets valid_out=1, or on reset.

Reset
REQ-029 With rst=1 at an edge, the block SHALL set PC=RESET_PC, state=FIRST, valid_out=0, instr_out=0, pc_out=RESET_PC and hold register=0.
REQ-030 rst SHALL override stall and redirect. Reset mid-way through a long instruction SHALL abandon it with no valid_out pulse.
REQ-031 Reset SHALL NOT clear memory contents. A write_enable write in a reset cycle SHALL still take effect.
REQ-032 valid_out SHALL be 0 in the first cycle after reset is released; the first instruction appears after the first non-reset edge.

Verification
REQ-033 Load and short fetch. Hold rst; write mem[0..2]=0x0070,0x0071,0x0072; release rst. -> valid_out=1 on three consecutive cycles, instr_out=0x00700000,0x00710000,0x00720000, pc_out=0,1,2.
REQ-034 Long instruction. mem[4]=0x8005, mem[5]=0x1234, mem[6]=0x0001, redirect_pc=4. -> one cycle with valid_out=0, then instr_out=0x80051234 with pc_out=4, then instr_out=0x00010000 with pc_out=6.
REQ-035 Stall. Assert stall for 3 cycles while instr_out=0x00710000 and valid_out=1. -> outputs held for all 3 cycles; the next instruction appears one cycle after stall falls.
REQ-036 Redirect in SECOND. Assert redirect with redirect_pc=0x20 in the cycle after the first word of a long instruction is latched. -> no pulse for that instruction; the next valid pc_out=0x20.
REQ-037 Wrap. With DEPTH=1024, redirect to PC=1023 where mem[1023]=0x0003 and mem[0]=0x0070. -> pc_out=1023, then pc_out=1024 with instr_out=0x00700000.
REQ-038 Reset mid-operation. Assert rst during SECOND together with stall=1 and redirect=1. -> next cycle valid_out=0, pc_out=RESET_PC, instr_out=0, and memory contents unchanged.
